frame_bank_sched: RTL

FRAME_BANK_SCHED -- requirements
Module: frame_bank_sched

---
 rtl/frame_bank_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/frame_bank_sched.sv
// -----------------------------------------------------------------------------
// frame_bank_sched
//
// Triple-buffer scheduler for a frame rotator. Three frame banks rotate between
// a writer (filling frames) and a reader (scanning frames out). Each bank is
// FREE, WRITING, READY or READING. The writer always owns one bank. A finished
// frame waits in READY until the reader claims it. A newer finished frame
// replaces an unread READY frame, and that replacement is counted as a drop.
//
// Parameters
//   BUFSIZE  words per frame bank
//   AW       width of the bank base addresses (3*BUFSIZE <= 2**AW)
//
// Ports
//   clk       clock
//   reset_n   asynchronous active-low reset
//   en        scheduler enable; pulses are ignored while low
//   wr_sof    writer finished a frame and starts the next one (1-cycle pulse)
//   rd_sof    reader starts a new output frame (1-cycle pulse)
//   wr_bank   bank the writer fills,  wr_base = wr_bank*BUFSIZE
//   rd_bank   bank the reader scans,  rd_base = rd_bank*BUFSIZE
//   rd_valid  reader bank holds a complete frame (0 = output black)
//   drop_cnt  saturating count of completed frames overwritten before read
//   rep_cnt   saturating count of reader frames that repeated a bank
// -----------------------------------------------------------------------------
module frame_bank_sched #(
    parameter int BUFSIZE = 76800,
    parameter int AW      = 18
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          wr_sof,
    input  logic          rd_sof,
    output logic [1:0]    wr_bank,
    output logic [1:0]    rd_bank,
    output logic [AW-1:0] wr_base,
    output logic [AW-1:0] rd_base,
    output logic          rd_valid,
    output logic [7:0]    drop_cnt,
    output logic [7:0]    rep_cnt
);

    typedef enum logic [1:0] {
        B_FREE    = 2'd0,
        B_WRITING = 2'd1,
        B_READY   = 2'd2,
        B_READING = 2'd3
    } bank_state_t;

    localparam logic [AW-1:0] BASE1 = AW'(BUFSIZE);
    localparam logic [AW-1:0] BASE2 = AW'(2 * BUFSIZE);

    function automatic logic [AW-1:0] base_of(input logic [1:0] b);
        case (b)
            2'd1:    base_of = BASE1;
            2'd2:    base_of = BASE2;
            default: base_of = '0;
        endcase
    endfunction

    bank_state_t   state_q [3];
    bank_state_t   state_d [3];
    logic [1:0]    wr_bank_q, wr_bank_d;
    logic [1:0]    rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_base_q, wr_base_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [7:0]    rep_cnt_q, rep_cnt_d;
    // Low for the first edge after reset release so a pulse coincident with
    // release is never acted on.
    logic          armed_q;

    logic [2:0] is_wr, is_rdy, is_rdg;
    logic       illegal;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_flag
            assign is_wr[gi]  = (state_q[gi] == B_WRITING);
            assign is_rdy[gi] = (state_q[gi] == B_READY);
            assign is_rdg[gi] = (state_q[gi] == B_READING);
        end
    endgenerate

    assign illegal = !$onehot(is_wr) || !$onehot0(is_rdy) || !$onehot0(is_rdg);

    logic       acc_wr, acc_rd;
    logic       found, has_ready;
    logic [1:0] ready_idx;

    assign acc_wr = en && armed_q && wr_sof;
    assign acc_rd = en && armed_q && rd_sof;

    always_comb begin
        for (int i = 0; i < 3; i++) state_d[i] = state_q[i];
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        rd_valid_d = rd_valid_q;
        drop_cnt_d = drop_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        found      = 1'b0;
        has_ready  = 1'b0;
        ready_idx  = 2'd0;

        // Writer step first, so a simultaneous reader sees the new READY bank.
        if (acc_wr) begin
            if (illegal) begin
                state_d[0] = B_WRITING;
                state_d[1] = B_FREE;
                state_d[2] = B_FREE;
                wr_bank_d  = 2'd0;
                rd_bank_d  = 2'd1;
                rd_valid_d = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (state_d[i] == B_READY) begin
                        state_d[i] = B_FREE;
                        if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    if (state_d[i] == B_WRITING) state_d[i] = B_READY;
                end
                // Choose the new writer bank before the reader frees its old one.
                for (int i = 0; i < 3; i++) begin
                    if (!found && state_d[i] == B_FREE) begin
                        state_d[i] = B_WRITING;
                        wr_bank_d  = 2'(i);
                        found      = 1'b1;
                    end
                end
            end
        end

        if (acc_rd) begin
            for (int i = 0; i < 3; i++) begin
                if (state_d[i] == B_READY) begin
                    has_ready = 1'b1;
                    ready_idx = 2'(i);
                end
            end
            if (has_ready) begin
                for (int i = 0; i < 3; i++) begin
                    if (state_d[i] == B_READING) state_d[i] = B_FREE;
                end
                state_d[ready_idx] = B_READING;
                rd_bank_d          = ready_idx;
                rd_valid_d         = 1'b1;
            end else if (rd_valid_q && rep_cnt_d != 8'hFF) begin
                rep_cnt_d = rep_cnt_d + 8'd1;
            end
        end

        wr_base_d = base_of(wr_bank_d);
        rd_base_d = base_of(rd_bank_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q[0] <= B_WRITING;
            state_q[1] <= B_FREE;
            state_q[2] <= B_FREE;
            wr_bank_q  <= 2'd0;
            rd_bank_q  <= 2'd1;
            wr_base_q  <= '0;
            rd_base_q  <= BASE1;
            rd_valid_q <= 1'b0;
            drop_cnt_q <= 8'd0;
            rep_cnt_q  <= 8'd0;
            armed_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) state_q[i] <= state_d[i];
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_base_q  <= wr_base_d;
            rd_base_q  <= rd_base_d;
            rd_valid_q <= rd_valid_d;
            drop_cnt_q <= drop_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            armed_q    <= 1'b1;
        end
    end

    assign wr_bank  = wr_bank_q;
    assign rd_bank  = rd_bank_q;
    assign wr_base  = wr_base_q;
    assign rd_base  = rd_base_q;
    assign rd_valid = rd_valid_q;
    assign drop_cnt = drop_cnt_q;
    assign rep_cnt  = rep_cnt_q;

endmodule
